rom_read_arbiter: RTL and testbench

- Shares one single-port, one-cycle-latency sprite/board ROM (96-bit words, 12-bit address) between two read clients.
- Port 0 is the VGA pixel renderer; port 1 is the game-logic/board-state reader.
- Sits between the clients and the ROM instance. It drives the ROM address and returns the ROM output with a per-port valid strobe.
- Arbitration is round-robin, with optional strict priority for port 0 and a starvation guard for port 1.

---
 rtl/rom_read_arbiter.sv | 89 ++++++++
 tb/tb_rom_read_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter.sv
// Two-client read arbiter for a single-port, one-cycle-latency ROM.
// Round-robin with optional port 0 priority and a port 1 starvation guard.
module rom_read_arbiter #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pri0,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    output logic                  gnt0,
    output logic                  rvalid0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    logic                  last_win;
    logic [CW-1:0]         starve_cnt;
    logic [ADDR_WIDTH-1:0] last_addr;

    // Grant decision; last_win==1 means port 1 won last, so a plain tie goes to port 0.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && !req1) begin
                gnt0 = 1'b1;
            end else if (req1 && !req0) begin
                gnt1 = 1'b1;
            end else if (req0 && req1) begin
                if (starve_cnt == MAX_CNT) begin
                    gnt1 = 1'b1;
                end else if (pri0 || last_win) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end
        end
    end

    // Hold the previous address when idle so the ROM input never floats.
    always_comb begin
        rom_addr = last_addr;
        if (gnt0) begin
            rom_addr = addr0;
        end else if (gnt1) begin
            rom_addr = addr1;
        end
    end

    assign rdata = rom_q;

    // Grant stage -> ROM read stage
    always_ff @(posedge clk) begin
        if (rst) begin
            last_win   <= 1'b1;
            starve_cnt <= '0;
            last_addr  <= '0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
        end else begin
            rvalid0   <= gnt0;
            rvalid1   <= gnt1;
            last_addr <= rom_addr;
            if (gnt0) begin
                last_win <= 1'b0;
            end else if (gnt1) begin
                last_win <= 1'b1;
            end
            if (!req1 || gnt1) begin
                starve_cnt <= '0;
            end else if (starve_cnt != MAX_CNT) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter: per-cycle vector table plus
// multi-cycle priority/starvation/reset sequences against a behavioural ROM.
module tb_rom_read_arbiter;

    localparam int DW = 96;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst, pri0, req0, req1;
    logic [AW-1:0] addr0, addr1, rom_addr;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata, rom_q;

    int errors = 0;
    int checks = 0;

    logic exp_rv0, exp_rv1;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] romw(input logic [AW-1:0] a);
        return {4{a ^ 12'hA5C, a}};
    endfunction

    always @(posedge clk) rom_q <= romw(rom_addr);

    rom_read_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst), .pri0(pri0),
        .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .rom_addr(rom_addr), .rom_q(rom_q)
    );

    typedef struct {
        logic          rst, pri0, req0;
        logic [AW-1:0] a0;
        logic          req1;
        logic [AW-1:0] a1;
        logic          g0, g1;
        logic [AW-1:0] ra;
        logic          v0, v1;
        logic [AW-1:0] da;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input logic r, input logic p, input logic q0, input logic [AW-1:0] a0,
                                input logic q1, input logic [AW-1:0] a1, input logic g0, input logic g1,
                                input logic [AW-1:0] ra, input logic v0, input logic v1, input logic [AW-1:0] da);
        vec_t v;
        v.rst = r; v.pri0 = p; v.req0 = q0; v.a0 = a0; v.req1 = q1; v.a1 = a1;
        v.g0 = g0; v.g1 = g1; v.ra = ra; v.v0 = v0; v.v1 = v1; v.da = da;
        return v;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive rst/req with pri0=1, a0=0A0, a1=0B0 for n cycles; gnt1 expected only at index g1_at.
    task automatic phase(input string nm, input logic r, input logic q1, input int n, input int g1_at);
        logic eg0, eg1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = r; pri0 = 1'b1; req0 = 1'b1; req1 = q1;
            addr0 = 12'h0A0; addr1 = 12'h0B0;
            #1;
            eg1 = !r && q1 && (i == g1_at);
            eg0 = !r && !eg1;
            chk1($sformatf("%s[%0d] gnt0", nm, i), gnt0, eg0);
            chk1($sformatf("%s[%0d] gnt1", nm, i), gnt1, eg1);
            chk1($sformatf("%s[%0d] rvalid0", nm, i), rvalid0, exp_rv0);
            chk1($sformatf("%s[%0d] rvalid1", nm, i), rvalid1, exp_rv1);
            if (exp_rv0 || exp_rv1)
                chkw($sformatf("%s[%0d] rdata", nm, i), rdata, romw(exp_rv1 ? 12'h0B0 : 12'h0A0));
            exp_rv0 = eg0;
            exp_rv1 = eg1;
        end
    endtask

    initial begin
        rst = 1'b1; pri0 = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = '0; addr1 = '0;

        //                rst pri q0 a0      q1 a1      g0 g1 rom     v0 v1 data
        tbl[0]  = mk(1, 0, 1, 12'h001, 1, 12'h002, 0, 0, 12'h000, 0, 0, 12'h000);
        tbl[1]  = mk(1, 0, 1, 12'h001, 1, 12'h002, 0, 0, 12'h000, 0, 0, 12'h000);
        tbl[2]  = mk(0, 0, 1, 12'h001, 1, 12'h002, 1, 0, 12'h001, 0, 0, 12'h000);
        tbl[3]  = mk(0, 0, 1, 12'h005, 0, 12'h002, 1, 0, 12'h005, 1, 0, 12'h001);
        tbl[4]  = mk(0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 12'h005, 1, 0, 12'h005);
        tbl[5]  = mk(0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 12'h005, 0, 0, 12'h000);
        tbl[6]  = mk(0, 0, 1, 12'h010, 1, 12'h020, 0, 1, 12'h020, 0, 0, 12'h000);
        tbl[7]  = mk(0, 0, 1, 12'h010, 1, 12'h020, 1, 0, 12'h010, 0, 1, 12'h020);
        tbl[8]  = mk(0, 0, 1, 12'h010, 1, 12'h020, 0, 1, 12'h020, 1, 0, 12'h010);
        tbl[9]  = mk(0, 0, 1, 12'h010, 1, 12'h020, 1, 0, 12'h010, 0, 1, 12'h020);
        tbl[10] = mk(0, 0, 0, 12'h000, 1, 12'h000, 0, 1, 12'h000, 1, 0, 12'h010);
        for (int k = 1; k < 8; k++)
            tbl[10 + k] = mk(0, 0, 0, 12'h000, 1, 12'(k), 0, 1, 12'(k), 0, 1, 12'(k - 1));
        tbl[18] = mk(0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 12'h007, 0, 1, 12'h007);
        tbl[19] = mk(0, 0, 0, 12'h000, 1, 12'h033, 0, 1, 12'h033, 0, 0, 12'h000);
        tbl[20] = mk(1, 0, 1, 12'h044, 1, 12'h055, 0, 0, 12'h033, 0, 1, 12'h033);
        tbl[21] = mk(1, 0, 1, 12'h044, 1, 12'h055, 0, 0, 12'h000, 0, 0, 12'h000);
        tbl[22] = mk(0, 0, 1, 12'h044, 1, 12'h055, 1, 0, 12'h044, 0, 0, 12'h000);
        tbl[23] = mk(0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 12'h044, 1, 0, 12'h044);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; pri0 = tbl[i].pri0;
            req0 = tbl[i].req0; addr0 = tbl[i].a0;
            req1 = tbl[i].req1; addr1 = tbl[i].a1;
            #1;
            chk1($sformatf("v%0d gnt0", i), gnt0, tbl[i].g0);
            chk1($sformatf("v%0d gnt1", i), gnt1, tbl[i].g1);
            chkw($sformatf("v%0d rom_addr", i), DW'(rom_addr), DW'(tbl[i].ra));
            chk1($sformatf("v%0d rvalid0", i), rvalid0, tbl[i].v0);
            chk1($sformatf("v%0d rvalid1", i), rvalid1, tbl[i].v1);
            if (tbl[i].v0 || tbl[i].v1)
                chkw($sformatf("v%0d rdata", i), rdata, romw(tbl[i].da));
        end

        // Priority with starvation guard: 15 x gnt0 then one gnt1, repeating.
        exp_rv0 = 1'b0;
        exp_rv1 = 1'b0;
        phase("starve_a", 1'b0, 1'b1, 16, 15);
        phase("starve_b", 1'b0, 1'b1, 16, 15);
        phase("starve_c", 1'b0, 1'b1, 16, 15);

        // Dropping req1 clears the starvation count.
        phase("drop_pre", 1'b0, 1'b1, 10, -1);
        phase("drop_gap", 1'b0, 1'b0, 1, -1);
        phase("drop_post", 1'b0, 1'b1, 16, 15);

        // Reset mid-count clears the starvation count; rvalid from the last grant still shows.
        phase("rst_pre", 1'b0, 1'b1, 10, -1);
        phase("rst_mid", 1'b1, 1'b1, 1, -1);
        phase("rst_post", 1'b0, 1'b1, 16, 15);

        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        #1;
        chk1("tail rvalid1", rvalid1, exp_rv1);
        chk1("tail rvalid0", rvalid0, exp_rv0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
